// File: rtl/mem_copy_engine.sv
// Block-wise memory-to-memory copy engine with bounds checking and
// overlap-safe direction selection (memmove semantics).
module mem_copy_engine #(
  parameter int size       = 1024,
  parameter int blocks     = 4,
  parameter int log_size   = 10,
  parameter int cell_width = 32,
  parameter int width      = blocks * cell_width
) (
  input  logic                in_clk,
  input  logic                in_reset,
  input  logic                in_start,
  input  logic [log_size-1:0] in_src,
  input  logic [log_size-1:0] in_dst,
  input  logic [log_size-1:0] in_count,
  output logic                out_busy,
  output logic                out_done,
  output logic                out_error,
  output logic [log_size-1:0] out_mem_address,
  output logic [width-1:0]    out_mem_data,
  output logic                out_mem_read_en,
  output logic                out_mem_write_en,
  input  logic [width-1:0]    in_mem_data
);
  localparam int ext_width = log_size + blocks;

  typedef enum logic [2:0] {IDLE, CHECK, READ, WAIT, WRITE, DONE} state_t;

  state_t              state_reg;
  logic [log_size-1:0] src_reg;
  logic [log_size-1:0] dst_reg;
  logic [log_size-1:0] count_reg;
  logic [log_size-1:0] idx_reg;
  logic [log_size-1:0] remaining_reg;
  logic                descend_reg;
  logic [width-1:0]    buffer_reg;

  logic [ext_width-1:0] src_end;
  logic [ext_width-1:0] dst_end;
  logic                 out_of_range;
  logic                 descend_next;
  logic [log_size-1:0]  first_idx;
  logic [log_size-1:0]  idx_next;

  function automatic logic [log_size-1:0] cell_addr(input logic [log_size-1:0] base,
                                                    input logic [log_size-1:0] index);
    cell_addr = base + index * log_size'(blocks);
  endfunction

  // Ends are computed wide so a region running past the top cannot wrap.
  always_comb begin
    src_end      = ext_width'(src_reg) + ext_width'(count_reg) * ext_width'(blocks);
    dst_end      = ext_width'(dst_reg) + ext_width'(count_reg) * ext_width'(blocks);
    out_of_range = (src_end > ext_width'(size)) || (dst_end > ext_width'(size));
    descend_next = (dst_reg > src_reg) && (ext_width'(dst_reg) < src_end);
    first_idx    = descend_next ? (count_reg - log_size'(1)) : '0;
    idx_next     = descend_reg ? (idx_reg - log_size'(1)) : (idx_reg + log_size'(1));
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_reg        <= IDLE;
      src_reg          <= '0;
      dst_reg          <= '0;
      count_reg        <= '0;
      idx_reg          <= '0;
      remaining_reg    <= '0;
      descend_reg      <= 1'b0;
      buffer_reg       <= '0;
      out_busy         <= 1'b0;
      out_done         <= 1'b0;
      out_error        <= 1'b0;
      out_mem_address  <= '0;
      out_mem_read_en  <= 1'b0;
      out_mem_write_en <= 1'b0;
    end else begin
      out_done         <= 1'b0;
      out_error        <= 1'b0;
      out_mem_read_en  <= 1'b0;
      out_mem_write_en <= 1'b0;
      out_mem_address  <= '0;
      unique case (state_reg)
        IDLE: begin
          if (in_start) begin
            src_reg   <= in_src;
            dst_reg   <= in_dst;
            count_reg <= in_count;
            out_busy  <= 1'b1;
            state_reg <= CHECK;
          end
        end
        CHECK: begin
          if (out_of_range) begin
            out_error <= 1'b1;
            out_busy  <= 1'b0;
            state_reg <= IDLE;
          end else if (count_reg == '0) begin
            out_done  <= 1'b1;
            state_reg <= DONE;
          end else begin
            descend_reg     <= descend_next;
            idx_reg         <= first_idx;
            remaining_reg   <= count_reg;
            out_mem_read_en <= 1'b1;
            out_mem_address <= cell_addr(src_reg, first_idx);
            state_reg       <= READ;
          end
        end
        READ: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          buffer_reg       <= in_mem_data;
          out_mem_write_en <= 1'b1;
          out_mem_address  <= cell_addr(dst_reg, idx_reg);
          state_reg        <= WRITE;
        end
        WRITE: begin
          if (remaining_reg == log_size'(1)) begin
            out_done  <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg         <= idx_next;
            remaining_reg   <= remaining_reg - log_size'(1);
            out_mem_read_en <= 1'b1;
            out_mem_address <= cell_addr(src_reg, idx_next);
            state_reg       <= READ;
          end
        end
        DONE: begin
          out_busy  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          out_busy  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Write data is presented only while the write strobe is up.
  genvar gi;
  generate
    for (gi = 0; gi < blocks; gi++) begin : g_cell
      assign out_mem_data[gi*cell_width +: cell_width] =
        out_mem_write_en ? buffer_reg[gi*cell_width +: cell_width] : '0;
    end
  endgenerate

  a_rd_wr_exclusive: assert property (@(posedge in_clk) disable iff (!in_reset)
    !(out_mem_read_en && out_mem_write_en));

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed, table-driven bench for mem_copy_engine with a behavioural
// memory that returns read data one cycle after the read strobe.
module tb_mem_copy_engine;
  localparam int SIZE = 1024;
  localparam int BLOCKS = 4;
  localparam int LOG = 10;
  localparam int CW = 32;
  localparam int W = BLOCKS * CW;
  localparam int BUDGET = 100;

  logic           clk = 1'b0;
  logic           in_reset;
  logic           in_start;
  logic [LOG-1:0] in_src;
  logic [LOG-1:0] in_dst;
  logic [LOG-1:0] in_count;
  logic           out_busy;
  logic           out_done;
  logic           out_error;
  logic [LOG-1:0] out_mem_address;
  logic [W-1:0]   out_mem_data;
  logic           out_mem_read_en;
  logic           out_mem_write_en;
  logic [W-1:0]   in_mem_data;

  always #5 clk = ~clk;

  mem_copy_engine #(
    .size(SIZE), .blocks(BLOCKS), .log_size(LOG), .cell_width(CW), .width(W)
  ) dut (
    .in_clk(clk),
    .in_reset(in_reset),
    .in_start(in_start),
    .in_src(in_src),
    .in_dst(in_dst),
    .in_count(in_count),
    .out_busy(out_busy),
    .out_done(out_done),
    .out_error(out_error),
    .out_mem_address(out_mem_address),
    .out_mem_data(out_mem_data),
    .out_mem_read_en(out_mem_read_en),
    .out_mem_write_en(out_mem_write_en),
    .in_mem_data(in_mem_data)
  );

  // Memory model: cell addr+k lives in lane k of the data bus.
  logic [CW-1:0] mem [0:SIZE-1];
  logic          preload_go = 1'b0;
  logic [CW-1:0] preload_pat = '0;

  always @(posedge clk) begin
    if (preload_go) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= preload_pat + CW'(i);
    end else if (out_mem_write_en) begin
      for (int k = 0; k < BLOCKS; k++)
        mem[LOG'(int'(out_mem_address) + k)] <= out_mem_data[k*CW +: CW];
    end
    if (out_mem_read_en) begin
      for (int k = 0; k < BLOCKS; k++)
        in_mem_data[k*CW +: CW] <= mem[LOG'(int'(out_mem_address) + k)];
    end else begin
      in_mem_data <= 'x;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic preload(input logic [CW-1:0] pat);
    @(negedge clk);
    preload_pat = pat;
    preload_go  = 1'b1;
    @(posedge clk);
    #1 preload_go = 1'b0;
  endtask

  int res_done_cyc, res_err_cyc, res_n_done, res_n_err;
  int res_n_rd, res_n_wr, res_busy_bad, res_bus_bad;
  int addr_log[$];

  // Issues one command and watches every cycle until a few cycles past its end.
  task automatic run_cmd(input logic [LOG-1:0] s, input logic [LOG-1:0] d,
                         input logic [LOG-1:0] c, input int extra_at);
    int fin;
    logic exp_busy;
    in_src = s; in_dst = d; in_count = c; in_start = 1'b1;
    @(posedge clk);
    #1 in_start = 1'b0;
    res_done_cyc = 0; res_err_cyc = 0; res_n_done = 0; res_n_err = 0;
    res_n_rd = 0; res_n_wr = 0; res_busy_bad = 0; res_bus_bad = 0;
    addr_log.delete();
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (k == extra_at) begin
        in_start = 1'b1; in_src = 10'd5; in_dst = 10'd500; in_count = 10'd2;
      end else begin
        in_start = 1'b0;
      end
      if (out_done) begin
        res_n_done++;
        if (res_done_cyc == 0) res_done_cyc = k;
      end
      if (out_error) begin
        res_n_err++;
        if (res_err_cyc == 0) res_err_cyc = k;
      end
      if (out_mem_read_en) begin res_n_rd++; addr_log.push_back(int'(out_mem_address)); end
      if (out_mem_write_en) begin res_n_wr++; addr_log.push_back(int'(out_mem_address)); end
      if (out_mem_read_en && out_mem_write_en) res_bus_bad++;
      if (!out_mem_write_en && out_mem_data != '0) res_bus_bad++;
      if (!out_mem_read_en && !out_mem_write_en && out_mem_address != '0) res_bus_bad++;
      fin = (res_done_cyc != 0) ? res_done_cyc : res_err_cyc;
      exp_busy = (fin == 0) || (k == res_done_cyc);
      if (out_busy != exp_busy) res_busy_bad++;
      if (fin != 0 && k >= fin + 3) break;
    end
    in_start = 1'b0;
  endtask

  typedef struct {
    logic [LOG-1:0] src;
    logic [LOG-1:0] dst;
    logic [LOG-1:0] count;
    logic [CW-1:0]  pat;
    int             err_cyc;
    int             done_cyc;
    int             xfers;
    int             rd0;
    int             wr0;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int bad, a, n;
    int exp_log[6];
    logic [CW-1:0] exp_cell;

    vecs[0]  = '{10'd0,    10'd64,   10'd4,  32'h100, 0, 14, 4, 0,    64};
    vecs[1]  = '{10'd0,    10'd4,    10'd3,  32'h0,   0, 11, 3, 8,    12};
    vecs[2]  = '{10'd1020, 10'd0,    10'd1,  32'h5000, 0, 5, 1, 1020, 0};
    vecs[3]  = '{10'd1021, 10'd0,    10'd1,  32'h6000, 2, 0, 0, -1,   -1};
    vecs[4]  = '{10'd0,    10'd1000, 10'd7,  32'h7000, 2, 0, 0, -1,   -1};
    vecs[5]  = '{10'd10,   10'd20,   10'd0,  32'h800, 0, 2,  0, -1,   -1};
    vecs[6]  = '{10'd8,    10'd4,    10'd3,  32'h300, 0, 11, 3, 8,    4};
    vecs[7]  = '{10'd100,  10'd100,  10'd2,  32'h700, 0, 8,  2, 100,  100};
    vecs[8]  = '{10'd1023, 10'd0,    10'd0,  32'h900, 0, 2,  0, -1,   -1};
    vecs[9]  = '{10'd0,    10'd1020, 10'd1,  32'hA00, 0, 5,  1, 0,    1020};
    vecs[10] = '{10'd1000, 10'd0,    10'd10, 32'hC00, 2, 0,  0, -1,   -1};
    vecs[11] = '{10'd0,    10'd12,   10'd3,  32'hB00, 0, 11, 3, 0,    12};

    in_reset = 1'b1; in_start = 1'b0; in_src = '0; in_dst = '0; in_count = '0;
    #2 in_reset = 1'b0;
    #1;
    check("reset_busy", out_busy, 0);
    check("reset_done_error", {out_done, out_error}, 0);
    check("reset_enables", {out_mem_read_en, out_mem_write_en}, 0);
    check("reset_bus", {out_mem_address, out_mem_data}, 0);
    in_start = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset_holds_idle", out_busy, 0);
    in_start = 1'b0;
    @(negedge clk) in_reset = 1'b1;

    for (int v = 0; v < 12; v++) begin
      preload(vecs[v].pat);
      run_cmd(vecs[v].src, vecs[v].dst, vecs[v].count, 0);
      $display("vec %0d src=%0d dst=%0d count=%0d done_cyc=%0d err_cyc=%0d reads=%0d writes=%0d",
               v, vecs[v].src, vecs[v].dst, vecs[v].count, res_done_cyc, res_err_cyc,
               res_n_rd, res_n_wr);
      check($sformatf("v%0d_err_cycle", v), res_err_cyc, vecs[v].err_cyc);
      check($sformatf("v%0d_done_cycle", v), res_done_cyc, vecs[v].done_cyc);
      check($sformatf("v%0d_done_pulses", v), res_n_done, (vecs[v].done_cyc != 0) ? 1 : 0);
      check($sformatf("v%0d_err_pulses", v), res_n_err, (vecs[v].err_cyc != 0) ? 1 : 0);
      check($sformatf("v%0d_reads", v), res_n_rd, vecs[v].xfers);
      check($sformatf("v%0d_writes", v), res_n_wr, vecs[v].xfers);
      check($sformatf("v%0d_busy", v), res_busy_bad, 0);
      check($sformatf("v%0d_bus_idle", v), res_bus_bad, 0);
      check($sformatf("v%0d_first_rd", v), (addr_log.size() > 0) ? addr_log[0] : -1, vecs[v].rd0);
      check($sformatf("v%0d_first_wr", v), (addr_log.size() > 1) ? addr_log[1] : -1, vecs[v].wr0);
      bad = 0;
      n = int'(vecs[v].count) * BLOCKS;
      for (int i = 0; i < n; i++) begin
        a = int'(vecs[v].dst) + i;
        if (a < SIZE) begin
          exp_cell = (vecs[v].err_cyc != 0) ? vecs[v].pat + CW'(a)
                                            : vecs[v].pat + CW'(int'(vecs[v].src) + i);
          if (mem[a] != exp_cell) bad++;
        end
      end
      a = int'(vecs[v].dst) + n;
      if (a < SIZE && mem[a] != vecs[v].pat + CW'(a)) bad++;
      a = int'(vecs[v].dst) - 1;
      if (a >= 0 && mem[a] != vecs[v].pat + CW'(a)) bad++;
      check($sformatf("v%0d_data_bad_cells", v), bad, 0);
    end

    // Overlapping copy must walk the address bus downwards.
    preload(32'h0);
    run_cmd(10'd0, 10'd4, 10'd3, 0);
    exp_log[0] = 8; exp_log[1] = 12; exp_log[2] = 4;
    exp_log[3] = 8; exp_log[4] = 0;  exp_log[5] = 4;
    $display("overlap log length=%0d", addr_log.size());
    check("ovl_log_len", addr_log.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < addr_log.size()) check($sformatf("ovl_log_%0d", k), addr_log[k], exp_log[k]);

    // Reset asserted during the second WRITE of a 4-transfer copy.
    preload(32'h100);
    in_src = 10'd0; in_dst = 10'd64; in_count = 10'd4; in_start = 1'b1;
    @(posedge clk);
    #1 in_start = 1'b0;
    repeat (7) @(negedge clk);
    check("midrst_wr_en_before", out_mem_write_en, 1);
    check("midrst_addr_before", out_mem_address, 68);
    in_reset = 1'b0;
    #1;
    $display("mid-copy reset busy=%0d rd=%0d wr=%0d addr=%0d", out_busy,
             out_mem_read_en, out_mem_write_en, out_mem_address);
    check("midrst_busy", out_busy, 0);
    check("midrst_enables", {out_mem_read_en, out_mem_write_en}, 0);
    check("midrst_bus", {out_mem_address, out_mem_data}, 0);
    check("midrst_done_error", {out_done, out_error}, 0);
    @(posedge clk);
    @(negedge clk) in_reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) if (mem[64 + i] != 32'h100 + CW'(i)) bad++;
    for (int i = 4; i < 16; i++) if (mem[64 + i] != 32'h140 + CW'(i)) bad++;
    check("midrst_cells_bad", bad, 0);
    run_cmd(10'd4, 10'd68, 10'd1, 0);
    $display("post-reset command done_cyc=%0d", res_done_cyc);
    check("postrst_done_cycle", res_done_cyc, 5);
    bad = 0;
    for (int i = 0; i < 4; i++) if (mem[68 + i] != 32'h104 + CW'(i)) bad++;
    check("postrst_cells_bad", bad, 0);

    // A start pulse while busy must change nothing.
    preload(32'h100);
    run_cmd(10'd0, 10'd64, 10'd4, 5);
    $display("busy-start command done_cyc=%0d done_pulses=%0d", res_done_cyc, res_n_done);
    check("busystart_done_cycle", res_done_cyc, 14);
    check("busystart_done_pulses", res_n_done, 1);
    check("busystart_reads", res_n_rd, 4);
    check("busystart_writes", res_n_wr, 4);
    check("busystart_busy", res_busy_bad, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[64 + i] != 32'h100 + CW'(i)) bad++;
    for (int i = 0; i < 8; i++) if (mem[500 + i] != 32'h100 + CW'(500 + i)) bad++;
    check("busystart_cells_bad", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
